muldiv: RTL
===========

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, datapath width; legal values 32 and 64 only.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL provide port op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-006 SHALL provide port dword  input  1  1 = WIDTH-bit op, 0 = 32-bit op; forced to 0 when WIDTH=32.
REQ-007 SHALL provide port a  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
REQ-008 SHALL provide port b  input  WIDTH  multiplier / divisor.
REQ-009 SHALL provide port kill  input  1  abort the in-flight operation.
REQ-010 SHALL provide port busy  output  1  iterative operation in flight.
REQ-011 SHALL provide port done  output  1  one-cycle pulse; hi/lo valid with the new result.
REQ-012 SHALL provide ports hi and lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-013 SHALL contain states IDLE, CALC and FIX; busy=1 exactly in CALC and FIX.
REQ-014 SHALL accept start in IDLE with op 0-3: latch operands, take absolute values for signed ops, load counter N (N = WIDTH if dword=1, else 32), go to CALC.
REQ-015 SHALL in 32-bit mode use a[31:0] and b[31:0] only, sign-extended for signed ops and zero-extended for unsigned ops.
REQ-016 SHALL in CALC retire one multiplier bit (shift-add) or one quotient bit (restoring subtract) per cycle; N decrements; at N=1 go to FIX.
REQ-017 SHALL in FIX apply sign correction, write hi/lo, pulse done and return to IDLE.
REQ-018 SHALL, for start in cycle t, hold busy high in cycles t+1..t+N+1, assert done in t+N+2, and hold busy low in t+N+2.
REQ-019 SHALL write hi = product upper half and lo = product lower half for multiply.
REQ-020 SHALL write lo = quotient (truncated toward zero) and hi = remainder (sign of dividend) for divide.
REQ-021 SHALL in 32-bit mode write hi and lo each sign-extended from bit 31 when WIDTH=64.
REQ-022 SHALL on divisor 0 run full latency, then write lo = all-ones (32-bit: sign-extended 0xFFFFFFFF) and hi = dividend (per REQ-015/021).
REQ-023 SHALL on signed MIN / -1 write lo = MIN and hi = 0.
REQ-024 SHALL on start in IDLE with MTHI/MTLO write a to hi/lo at the next edge, with no busy and no done.
REQ-025 SHALL ignore start while busy=1 and start with op 6-7; hi/lo are unchanged in both cases.
REQ-026 SHALL on kill=1 in CALC or FIX return to IDLE at the next edge, with no done and hi/lo unchanged.
REQ-027 SHALL give kill priority over start when both are asserted in the same cycle; nothing is accepted.
REQ-028 SHALL keep hi/lo stable except on done or an MTHI/MTLO write.

Reset
REQ-029 SHALL on rst=1 at a clock edge enter IDLE and clear hi=0, lo=0, busy=0, done=0 and the counter.
REQ-030 SHALL on rst=1 mid-operation abandon the operation with no done pulse; rst has priority over kill and start.

Verification
REQ-031 SHALL cover: WIDTH=64, MULT dword=1, a=-1, b=2 at t -> done at t+66, lo=0xFFFFFFFFFFFFFFFE, hi=0xFFFFFFFFFFFFFFFF.
REQ-032 SHALL cover: MULTU dword=0, a=b=0xFFFFFFFF -> done at t+34, lo=0x0000000000000001, hi=0xFFFFFFFFFFFFFFFE.
REQ-033 SHALL cover: DIV dword=0, a=-7, b=2 -> lo=0xFFFFFFFFFFFFFFFD, hi=0xFFFFFFFFFFFFFFFF.
REQ-034 SHALL cover: DIVU dword=0, a=5, b=0 -> lo=0xFFFFFFFFFFFFFFFF, hi=5; and DIV dword=1, a=0x8000000000000000, b=-1 -> lo=0x8000000000000000, hi=0.
REQ-035 SHALL cover: MTHI a=0x1234 -> hi=0x1234 next cycle with busy=0; then MULT started, kill at t+10 -> no done, busy=0 at t+11, hi still 0x1234.
REQ-036 SHALL cover: start with a new op while busy -> ignored (done once, first op's result); rst at t+5 of a DIVU -> hi=lo=0, busy=0, no done.

Source files
------------

// File: rtl/muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One multiplier or quotient bit per cycle; operands handled as magnitudes with sign fixed up at the end.
module muldiv #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             dword,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int SH = WIDTH - 32;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t state_r, state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [WIDTH-1:0] acc_r, q_r, m_r;
  logic div_r, dword_r, neg_q_r, neg_r_r, bzero_r;
  logic busy_r, done_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic dword_s, sgn_s, is_div_s, accept_s, mt_s, fix_ok_s;
  logic a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s;
  logic [WIDTH:0] mul_sum_s, rem_sh_s;
  logic [WIDTH-1:0] rem_sub_s;
  logic ge_s;
  logic [2*WIDTH-1:0] prod_s, prod_al_s, prod_fix_s;
  logic [WIDTH-1:0] quot_s, rem_s, res_hi_s, res_lo_s;

  function automatic logic [WIDTH-1:0] sx32(input logic [31:0] x);
    sx32 = WIDTH'(signed'(x));
  endfunction

  function automatic logic [WIDTH-1:0] ext32(input logic [WIDTH-1:0] x, input logic dw, input logic sg);
    if (dw) begin
      ext32 = x;
    end else if (sg) begin
      ext32 = sx32(x[31:0]);
    end else begin
      ext32 = WIDTH'(x[31:0]);
    end
  endfunction

  // Operand decode, request qualification and per-cycle step arithmetic
  always_comb begin
    dword_s  = (WIDTH == 64) ? dword : 1'b0;
    sgn_s    = (op == 3'd0) || (op == 3'd2);
    is_div_s = (op == 3'd2) || (op == 3'd3);
    accept_s = (state_r == IDLE) && start && !kill && (op <= 3'd3);
    mt_s     = (state_r == IDLE) && start && !kill && ((op == 3'd4) || (op == 3'd5));
    fix_ok_s = (state_r == FIX) && !kill;
    a_ext_s  = ext32(a, dword_s, sgn_s);
    b_ext_s  = ext32(b, dword_s, sgn_s);
    a_neg_s  = sgn_s & a_ext_s[WIDTH-1];
    b_neg_s  = sgn_s & b_ext_s[WIDTH-1];
    a_mag_s  = a_neg_s ? -a_ext_s : a_ext_s;
    b_mag_s  = b_neg_s ? -b_ext_s : b_ext_s;
    // mul: {acc,q} shifts right; div: {acc,q} shifts left through a restoring subtract
    mul_sum_s = {1'b0, acc_r} + {1'b0, (q_r[0] ? m_r : {WIDTH{1'b0}})};
    rem_sh_s  = {acc_r, q_r[WIDTH-1]};
    ge_s      = rem_sh_s >= {1'b0, m_r};
    rem_sub_s = rem_sh_s[WIDTH-1:0] - m_r;
  end

  // Result assembly with sign correction and 32-bit sign extension
  always_comb begin
    prod_s     = {acc_r, q_r};
    prod_al_s  = dword_r ? prod_s : (prod_s >> SH);
    prod_fix_s = neg_q_r ? -prod_al_s : prod_al_s;
    quot_s     = bzero_r ? {WIDTH{1'b1}} : (neg_q_r ? -q_r : q_r);
    rem_s      = neg_r_r ? -acc_r : acc_r;
    if (div_r) begin
      if (dword_r) begin
        res_hi_s = rem_s;
        res_lo_s = quot_s;
      end else begin
        res_hi_s = sx32(rem_s[31:0]);
        res_lo_s = sx32(quot_s[31:0]);
      end
    end else begin
      if (dword_r) begin
        res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_fix_s[WIDTH-1:0];
      end else begin
        res_hi_s = sx32(prod_fix_s[63:32]);
        res_lo_s = sx32(prod_fix_s[31:0]);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (kill) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == CW'(1)) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch and iterative datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      m_r     <= {WIDTH{1'b0}};
      div_r   <= 1'b0;
      dword_r <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      bzero_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= dword_s ? CW'(WIDTH) : CW'(32);
      acc_r   <= {WIDTH{1'b0}};
      div_r   <= is_div_s;
      dword_r <= dword_s;
      neg_q_r <= a_neg_s ^ b_neg_s;
      neg_r_r <= a_neg_s;
      bzero_r <= (b_mag_s == {WIDTH{1'b0}});
      if (is_div_s) begin
        m_r <= b_mag_s;
        // 32-bit dividends are left-aligned so the quotient lands in the low bits
        q_r <= dword_s ? a_mag_s : (a_mag_s << SH);
      end else begin
        m_r <= a_mag_s;
        q_r <= b_mag_s;
      end
    end else if (state_r == CALC) begin
      cnt_r <= cnt_r - CW'(1);
      if (div_r) begin
        acc_r <= ge_s ? rem_sub_s : rem_sh_s[WIDTH-1:0];
        q_r   <= {q_r[WIDTH-2:0], ge_s};
      end else begin
        acc_r <= mul_sum_s[WIDTH:1];
        q_r   <= {mul_sum_s[0], q_r[WIDTH-1:1]};
      end
    end
  end

  // Architectural HI/LO and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      done_r <= fix_ok_s;
      if (fix_ok_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else if (mt_s && (op == 3'd4)) begin
        hi_r <= a;
      end else if (mt_s) begin
        lo_r <= a;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
